// File: rtl/axi_burst_ptgen_master.sv
// AXI4 pattern-test master: writes NUM_BURSTS INCR bursts of an incrementing or LFSR
// pattern, reads them back, and counts mismatched beats and bad responses.
module axi_burst_ptgen_master #(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_M_AXI_ID_WIDTH   = 1,
    parameter int C_M_AXI_BURST_LEN  = 16,
    parameter int C_NUM_BURSTS       = 4,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_TARGET_BASE_ADDR = 32'h4000_0000
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic                            INIT_AXI_TXN,
    input  logic                            PATTERN_MODE,
    input  logic [31:0]                     PATTERN_SEED,
    output logic                            TXN_DONE,
    output logic                            ERROR,
    output logic [15:0]                     ERR_COUNT,
    output logic [2:0]                      dbg_state,
    output logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_AWID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [7:0]                      M_AXI_AWLEN,
    output logic [2:0]                      M_AXI_AWSIZE,
    output logic [1:0]                      M_AXI_AWBURST,
    output logic                            M_AXI_AWLOCK,
    output logic [3:0]                      M_AXI_AWCACHE,
    output logic [2:0]                      M_AXI_AWPROT,
    output logic [3:0]                      M_AXI_AWQOS,
    output logic [0:0]                      M_AXI_AWUSER,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WLAST,
    output logic [0:0]                      M_AXI_WUSER,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    input  logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_BID,
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,
    output logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_ARID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [7:0]                      M_AXI_ARLEN,
    output logic [2:0]                      M_AXI_ARSIZE,
    output logic [1:0]                      M_AXI_ARBURST,
    output logic                            M_AXI_ARLOCK,
    output logic [3:0]                      M_AXI_ARCACHE,
    output logic [2:0]                      M_AXI_ARPROT,
    output logic [3:0]                      M_AXI_ARQOS,
    output logic [0:0]                      M_AXI_ARUSER,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,
    input  logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_RID,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RLAST,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY
);

    localparam int DW     = C_M_AXI_DATA_WIDTH;
    localparam int AW     = C_M_AXI_ADDR_WIDTH;
    localparam int NBYTES = DW / 8;
    localparam int LANES  = DW / 32;
    localparam int CNT_W  = $clog2(C_NUM_BURSTS) + 1;
    localparam logic [8:0]       LAST_BEAT   = 9'(C_M_AXI_BURST_LEN - 1);
    localparam logic [CNT_W-1:0] LAST_BURST  = CNT_W'(C_NUM_BURSTS - 1);
    localparam logic [AW-1:0]    BURST_BYTES = AW'(C_M_AXI_BURST_LEN * NBYTES);

    typedef enum logic [2:0] {
        S_IDLE, S_WR_ADDR, S_WR_DATA, S_WR_RESP, S_RD_ADDR, S_RD_DATA, S_DONE
    } state_t;

    // Galois LFSR x^32+x^22+x^2+x+1 (right-shifting) or plain increment.
    function automatic logic [31:0] pat_step(input logic mode, input logic [31:0] v);
        if (mode)
            return {1'b0, v[31:1]} ^ (v[0] ? 32'h8020_0003 : 32'h0);
        else
            return v + 32'd1;
    endfunction

    function automatic logic [DW-1:0] expand(input logic [31:0] w);
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < LANES; i++)
            r[i*32 +: 32] = w ^ 32'(i);
        return r;
    endfunction

    state_t            state_q, state_d;
    logic              init_q, init_d;
    logic              mode_q, mode_d;
    logic [31:0]       wr_pat_q, wr_pat_d;
    logic [31:0]       rd_pat_q, rd_pat_d;
    logic [8:0]        beat_q, beat_d;
    logic [CNT_W-1:0]  burst_q, burst_d;
    logic [15:0]       err_cnt_q, err_cnt_d;
    logic              error_q, error_d;

    logic aw_valid, w_valid, b_ready, ar_valid, r_ready, done;
    logic start, last_beat, last_burst, rd_end, rd_mismatch, err_event;
    logic [31:0] seed_init;
    logic unused_ids;

    assign unused_ids  = ^{M_AXI_BID, M_AXI_RID};
    assign start       = INIT_AXI_TXN && !init_q && (state_q == S_IDLE || state_q == S_DONE);
    assign last_beat   = (beat_q == LAST_BEAT);
    assign last_burst  = (burst_q == LAST_BURST);
    assign rd_end      = M_AXI_RLAST || last_beat;
    assign rd_mismatch = (M_AXI_RDATA != expand(rd_pat_q));
    assign seed_init   = (PATTERN_MODE && PATTERN_SEED == 32'd0) ? 32'd1 : PATTERN_SEED;

    always_ff @(posedge ACLK) begin
        if (ARESET)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: if (start) state_d = S_WR_ADDR;
            S_WR_ADDR:      if (M_AXI_AWREADY) state_d = S_WR_DATA;
            S_WR_DATA:      if (M_AXI_WREADY && last_beat) state_d = S_WR_RESP;
            S_WR_RESP:      if (M_AXI_BVALID) state_d = last_burst ? S_RD_ADDR : S_WR_ADDR;
            S_RD_ADDR:      if (M_AXI_ARREADY) state_d = S_RD_DATA;
            S_RD_DATA:      if (M_AXI_RVALID && rd_end) state_d = last_burst ? S_DONE : S_RD_ADDR;
            default:        state_d = S_IDLE;
        endcase
    end

    always_comb begin
        aw_valid = 1'b0;
        w_valid  = 1'b0;
        b_ready  = 1'b0;
        ar_valid = 1'b0;
        r_ready  = 1'b0;
        done     = 1'b0;
        case (state_q)
            S_WR_ADDR: aw_valid = 1'b1;
            S_WR_DATA: w_valid  = 1'b1;
            S_WR_RESP: b_ready  = 1'b1;
            S_RD_ADDR: ar_valid = 1'b1;
            S_RD_DATA: r_ready  = 1'b1;
            S_DONE:    done     = 1'b1;
            default:   ;
        endcase
    end

    always_comb begin
        init_d    = INIT_AXI_TXN;
        mode_d    = mode_q;
        wr_pat_d  = wr_pat_q;
        rd_pat_d  = rd_pat_q;
        beat_d    = beat_q;
        burst_d   = burst_q;
        err_cnt_d = err_cnt_q;
        error_d   = error_q;
        err_event = 1'b0;
        if (start) begin
            mode_d    = PATTERN_MODE;
            wr_pat_d  = seed_init;
            rd_pat_d  = seed_init;
            beat_d    = '0;
            burst_d   = '0;
            err_cnt_d = '0;
            error_d   = 1'b0;
        end
        case (state_q)
            S_WR_DATA: if (M_AXI_WREADY) begin
                wr_pat_d = pat_step(mode_q, wr_pat_q);
                beat_d   = last_beat ? 9'd0 : beat_q + 9'd1;
            end
            S_WR_RESP: if (M_AXI_BVALID) begin
                burst_d   = last_burst ? '0 : burst_q + 1'b1;
                err_event = (M_AXI_BRESP != 2'b00);
            end
            S_RD_DATA: if (M_AXI_RVALID) begin
                rd_pat_d = pat_step(mode_q, rd_pat_q);
                // An early RLAST still closes the burst; a late one is caught by the beat count.
                if (rd_end) begin
                    beat_d  = 9'd0;
                    burst_d = last_burst ? burst_q : burst_q + 1'b1;
                end else begin
                    beat_d  = beat_q + 9'd1;
                end
                err_event = (M_AXI_RRESP != 2'b00) || rd_mismatch || (M_AXI_RLAST != last_beat);
            end
            default: ;
        endcase
        if (err_event) begin
            error_d = 1'b1;
            if (err_cnt_q != 16'hFFFF)
                err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            init_q    <= 1'b0;
            mode_q    <= 1'b0;
            wr_pat_q  <= '0;
            rd_pat_q  <= '0;
            beat_q    <= '0;
            burst_q   <= '0;
            err_cnt_q <= '0;
            error_q   <= 1'b0;
        end else begin
            init_q    <= init_d;
            mode_q    <= mode_d;
            wr_pat_q  <= wr_pat_d;
            rd_pat_q  <= rd_pat_d;
            beat_q    <= beat_d;
            burst_q   <= burst_d;
            err_cnt_q <= err_cnt_d;
            error_q   <= error_d;
        end
    end

    assign TXN_DONE  = done;
    assign ERROR     = error_q;
    assign ERR_COUNT = err_cnt_q;
    assign dbg_state = state_q;

    assign M_AXI_AWID    = '0;
    assign M_AXI_AWADDR  = C_TARGET_BASE_ADDR + AW'(burst_q) * BURST_BYTES;
    assign M_AXI_AWLEN   = 8'(C_M_AXI_BURST_LEN - 1);
    assign M_AXI_AWSIZE  = 3'($clog2(NBYTES));
    assign M_AXI_AWBURST = 2'b01;
    assign M_AXI_AWLOCK  = 1'b0;
    assign M_AXI_AWCACHE = 4'b0011;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWQOS   = 4'b0000;
    assign M_AXI_AWUSER  = 1'b0;
    assign M_AXI_AWVALID = aw_valid;

    assign M_AXI_WDATA   = expand(wr_pat_q);
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_WLAST   = w_valid && last_beat;
    assign M_AXI_WUSER   = 1'b0;
    assign M_AXI_WVALID  = w_valid;
    assign M_AXI_BREADY  = b_ready;

    assign M_AXI_ARID    = '0;
    assign M_AXI_ARADDR  = C_TARGET_BASE_ADDR + AW'(burst_q) * BURST_BYTES;
    assign M_AXI_ARLEN   = 8'(C_M_AXI_BURST_LEN - 1);
    assign M_AXI_ARSIZE  = 3'($clog2(NBYTES));
    assign M_AXI_ARBURST = 2'b01;
    assign M_AXI_ARLOCK  = 1'b0;
    assign M_AXI_ARCACHE = 4'b0011;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARQOS   = 4'b0000;
    assign M_AXI_ARUSER  = 1'b0;
    assign M_AXI_ARVALID = ar_valid;
    assign M_AXI_RREADY  = r_ready;

endmodule

// File: tb/tb_axi_burst_ptgen_master.sv
// Bench for axi_burst_ptgen_master: a default-size instance with a memory-backed slave
// (optional back-pressure, corruption, bad BRESP) and a 128-bit/256-beat LFSR instance.
`timescale 1ns/1ps
module tb_axi_burst_ptgen_master;

    localparam logic [31:0] BASE = 32'h4000_0000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] lfsr_next(input logic [31:0] v);
        return (v >> 1) ^ (v[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    // ---------------- instance 0: defaults ----------------
    logic m0_init, m0_mode, m0_done, m0_err;
    logic [31:0] m0_seed;
    logic [15:0] m0_cnt;
    logic [2:0]  m0_dbg;
    logic [0:0]  m0_awid, m0_awuser, m0_wuser, m0_bid, m0_arid, m0_aruser, m0_rid;
    logic [31:0] m0_awaddr, m0_araddr, m0_wdata, m0_rdata;
    logic [7:0]  m0_awlen, m0_arlen;
    logic [2:0]  m0_awsize, m0_arsize, m0_awprot, m0_arprot;
    logic [1:0]  m0_awburst, m0_arburst, m0_bresp, m0_rresp;
    logic [3:0]  m0_awcache, m0_arcache, m0_awqos, m0_arqos, m0_wstrb;
    logic m0_awlock, m0_arlock, m0_awvalid, m0_awready, m0_wlast, m0_wvalid, m0_wready;
    logic m0_bvalid, m0_bready, m0_arvalid, m0_arready, m0_rlast, m0_rvalid, m0_rready;

    axi_burst_ptgen_master u_dut0 (
        .ACLK(clk), .ARESET(rst), .INIT_AXI_TXN(m0_init), .PATTERN_MODE(m0_mode),
        .PATTERN_SEED(m0_seed), .TXN_DONE(m0_done), .ERROR(m0_err), .ERR_COUNT(m0_cnt),
        .dbg_state(m0_dbg),
        .M_AXI_AWID(m0_awid), .M_AXI_AWADDR(m0_awaddr), .M_AXI_AWLEN(m0_awlen),
        .M_AXI_AWSIZE(m0_awsize), .M_AXI_AWBURST(m0_awburst), .M_AXI_AWLOCK(m0_awlock),
        .M_AXI_AWCACHE(m0_awcache), .M_AXI_AWPROT(m0_awprot), .M_AXI_AWQOS(m0_awqos),
        .M_AXI_AWUSER(m0_awuser), .M_AXI_AWVALID(m0_awvalid), .M_AXI_AWREADY(m0_awready),
        .M_AXI_WDATA(m0_wdata), .M_AXI_WSTRB(m0_wstrb), .M_AXI_WLAST(m0_wlast),
        .M_AXI_WUSER(m0_wuser), .M_AXI_WVALID(m0_wvalid), .M_AXI_WREADY(m0_wready),
        .M_AXI_BID(m0_bid), .M_AXI_BRESP(m0_bresp), .M_AXI_BVALID(m0_bvalid),
        .M_AXI_BREADY(m0_bready),
        .M_AXI_ARID(m0_arid), .M_AXI_ARADDR(m0_araddr), .M_AXI_ARLEN(m0_arlen),
        .M_AXI_ARSIZE(m0_arsize), .M_AXI_ARBURST(m0_arburst), .M_AXI_ARLOCK(m0_arlock),
        .M_AXI_ARCACHE(m0_arcache), .M_AXI_ARPROT(m0_arprot), .M_AXI_ARQOS(m0_arqos),
        .M_AXI_ARUSER(m0_aruser), .M_AXI_ARVALID(m0_arvalid), .M_AXI_ARREADY(m0_arready),
        .M_AXI_RID(m0_rid), .M_AXI_RDATA(m0_rdata), .M_AXI_RRESP(m0_rresp),
        .M_AXI_RLAST(m0_rlast), .M_AXI_RVALID(m0_rvalid), .M_AXI_RREADY(m0_rready)
    );

    // ---------------- instance 1: 128-bit, 256 beats, 2 bursts ----------------
    logic m1_init, m1_mode, m1_done, m1_err;
    logic [31:0]  m1_seed, m1_awaddr, m1_araddr;
    logic [15:0]  m1_cnt, m1_wstrb;
    logic [2:0]   m1_dbg;
    logic [0:0]   m1_awid, m1_awuser, m1_wuser, m1_bid, m1_arid, m1_aruser, m1_rid;
    logic [127:0] m1_wdata, m1_rdata;
    logic [7:0]   m1_awlen, m1_arlen;
    logic [2:0]   m1_awsize, m1_arsize, m1_awprot, m1_arprot;
    logic [1:0]   m1_awburst, m1_arburst, m1_bresp, m1_rresp;
    logic [3:0]   m1_awcache, m1_arcache, m1_awqos, m1_arqos;
    logic m1_awlock, m1_arlock, m1_awvalid, m1_awready, m1_wlast, m1_wvalid, m1_wready;
    logic m1_bvalid, m1_bready, m1_arvalid, m1_arready, m1_rlast, m1_rvalid, m1_rready;

    axi_burst_ptgen_master #(
        .C_M_AXI_DATA_WIDTH(128), .C_M_AXI_BURST_LEN(256), .C_NUM_BURSTS(2)
    ) u_dut1 (
        .ACLK(clk), .ARESET(rst), .INIT_AXI_TXN(m1_init), .PATTERN_MODE(m1_mode),
        .PATTERN_SEED(m1_seed), .TXN_DONE(m1_done), .ERROR(m1_err), .ERR_COUNT(m1_cnt),
        .dbg_state(m1_dbg),
        .M_AXI_AWID(m1_awid), .M_AXI_AWADDR(m1_awaddr), .M_AXI_AWLEN(m1_awlen),
        .M_AXI_AWSIZE(m1_awsize), .M_AXI_AWBURST(m1_awburst), .M_AXI_AWLOCK(m1_awlock),
        .M_AXI_AWCACHE(m1_awcache), .M_AXI_AWPROT(m1_awprot), .M_AXI_AWQOS(m1_awqos),
        .M_AXI_AWUSER(m1_awuser), .M_AXI_AWVALID(m1_awvalid), .M_AXI_AWREADY(m1_awready),
        .M_AXI_WDATA(m1_wdata), .M_AXI_WSTRB(m1_wstrb), .M_AXI_WLAST(m1_wlast),
        .M_AXI_WUSER(m1_wuser), .M_AXI_WVALID(m1_wvalid), .M_AXI_WREADY(m1_wready),
        .M_AXI_BID(m1_bid), .M_AXI_BRESP(m1_bresp), .M_AXI_BVALID(m1_bvalid),
        .M_AXI_BREADY(m1_bready),
        .M_AXI_ARID(m1_arid), .M_AXI_ARADDR(m1_araddr), .M_AXI_ARLEN(m1_arlen),
        .M_AXI_ARSIZE(m1_arsize), .M_AXI_ARBURST(m1_arburst), .M_AXI_ARLOCK(m1_arlock),
        .M_AXI_ARCACHE(m1_arcache), .M_AXI_ARPROT(m1_arprot), .M_AXI_ARQOS(m1_arqos),
        .M_AXI_ARUSER(m1_aruser), .M_AXI_ARVALID(m1_arvalid), .M_AXI_ARREADY(m1_arready),
        .M_AXI_RID(m1_rid), .M_AXI_RDATA(m1_rdata), .M_AXI_RRESP(m1_rresp),
        .M_AXI_RLAST(m1_rlast), .M_AXI_RVALID(m1_rvalid), .M_AXI_RREADY(m1_rready)
    );

    // ---------------- scoreboard state ----------------
    logic [31:0]  exp_q[$];
    logic [127:0] exp_wide_q[$];
    logic [31:0]  aw_log[$], w_log[$], aw1_log[$];
    logic [127:0] w1_log[$];
    int w_cnt, w_mism, wlast_err, proto_err, awfmt_err, ar_cnt, w1_mism, wlast1_err;

    // ---------------- slave for instance 0 ----------------
    bit sa_bp;
    int sa_corrupt, sa_bad_b, sa_bcnt;
    logic [31:0] mem0 [0:63];
    logic [31:0] sa_wr_addr, sa_rd_addr;
    int sa_wbeat, sa_rbeat, rg0, wi0;
    bit sa_wopen, sa_bpend, sa_ractive;
    logic p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_rv, p_rr, p_wlast;
    logic [31:0] p_awaddr, p_araddr, p_wdata;
    logic [31:0] e0;

    initial begin
        {m0_awready, m0_wready, m0_bvalid, m0_arready, m0_rvalid, m0_rlast} = '0;
        m0_bid = '0; m0_rid = '0; m0_bresp = '0; m0_rresp = '0; m0_rdata = '0;
        {p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_rv, p_rr, p_wlast} = '0;
        sa_wopen = 0; sa_bpend = 0; sa_ractive = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                {m0_awready, m0_wready, m0_bvalid, m0_arready, m0_rvalid, m0_rlast} = '0;
                {p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_rv, p_rr, p_wlast} = '0;
                sa_wopen = 0; sa_bpend = 0; sa_ractive = 0;
                continue;
            end
            if (p_awv && !p_awr && (!m0_awvalid || m0_awaddr != p_awaddr)) proto_err++;
            if (p_wv && !p_wr && (!m0_wvalid || m0_wdata != p_wdata || m0_wlast != p_wlast)) proto_err++;
            if (p_arv && !p_arr && (!m0_arvalid || m0_araddr != p_araddr)) proto_err++;
            if (m0_wvalid && !sa_wopen) proto_err++;
            m0_awready = sa_bp ? 1'($urandom_range(0, 1)) : 1'b1;
            m0_wready  = sa_bp ? 1'($urandom_range(0, 1)) : 1'b1;
            m0_arready = sa_bp ? 1'($urandom_range(0, 1)) : 1'b1;
            m0_bvalid  = sa_bpend;
            m0_bresp   = (sa_bpend && sa_bcnt == sa_bad_b) ? 2'b10 : 2'b00;
            if (!(p_rv && !p_rr)) begin
                m0_rvalid = sa_ractive && (sa_bp ? 1'($urandom_range(0, 1)) : 1'b1);
                m0_rlast  = (sa_rbeat == 15);
                if (sa_ractive) begin
                    rg0 = int'((sa_rd_addr - BASE) / 4) + sa_rbeat;
                    m0_rdata = mem0[rg0] ^ ((rg0 == sa_corrupt) ? 32'h1 : 32'h0);
                end
            end
            if (m0_awvalid && m0_awready) begin
                aw_log.push_back(m0_awaddr);
                if (m0_awlen != 8'd15 || m0_awsize != 3'd2 || m0_awburst != 2'b01) awfmt_err++;
                sa_wr_addr = m0_awaddr; sa_wbeat = 0; sa_wopen = 1;
            end
            if (m0_wvalid && m0_wready) begin
                wi0 = int'((sa_wr_addr - BASE) / 4) + sa_wbeat;
                if (wi0 >= 0 && wi0 < 64) mem0[wi0] = m0_wdata;
                w_log.push_back(m0_wdata);
                if (exp_q.size() == 0) w_mism++;
                else begin
                    e0 = exp_q.pop_front();
                    if (m0_wdata != e0) w_mism++;
                end
                if (m0_wlast != (sa_wbeat == 15)) wlast_err++;
                w_cnt++; sa_wbeat++;
                if (m0_wlast) begin sa_wopen = 0; sa_bpend = 1; end
            end
            if (m0_bvalid && m0_bready) begin sa_bpend = 0; sa_bcnt++; end
            if (m0_arvalid && m0_arready) begin
                sa_rd_addr = m0_araddr; sa_rbeat = 0; sa_ractive = 1; ar_cnt++;
            end
            if (m0_rvalid && m0_rready) begin
                sa_rbeat++;
                if (m0_rlast) sa_ractive = 0;
            end
            p_awv = m0_awvalid; p_awr = m0_awready; p_awaddr = m0_awaddr;
            p_wv = m0_wvalid; p_wr = m0_wready; p_wdata = m0_wdata; p_wlast = m0_wlast;
            p_arv = m0_arvalid; p_arr = m0_arready; p_araddr = m0_araddr;
            p_rv = m0_rvalid; p_rr = m0_rready;
        end
    end

    // ---------------- ideal slave for instance 1 ----------------
    logic [127:0] mem1 [0:511];
    logic [31:0]  sb_wr_addr, sb_rd_addr;
    int sb_wbeat, sb_rbeat, rg1, wi1;
    bit sb_bpend, sb_ractive;
    logic [127:0] e1;

    initial begin
        m1_awready = 1'b1; m1_wready = 1'b1; m1_arready = 1'b1;
        m1_bvalid = 1'b0; m1_rvalid = 1'b0; m1_rlast = 1'b0;
        m1_bid = '0; m1_rid = '0; m1_bresp = '0; m1_rresp = '0; m1_rdata = '0;
        sb_bpend = 0; sb_ractive = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                m1_bvalid = 1'b0; m1_rvalid = 1'b0; sb_bpend = 0; sb_ractive = 0;
                continue;
            end
            m1_bvalid = sb_bpend;
            m1_rvalid = sb_ractive;
            m1_rlast  = (sb_rbeat == 255);
            if (sb_ractive) begin
                rg1 = int'((sb_rd_addr - BASE) / 16) + sb_rbeat;
                m1_rdata = mem1[rg1];
            end
            if (m1_awvalid && m1_awready) begin
                aw1_log.push_back(m1_awaddr);
                sb_wr_addr = m1_awaddr; sb_wbeat = 0;
            end
            if (m1_wvalid && m1_wready) begin
                wi1 = int'((sb_wr_addr - BASE) / 16) + sb_wbeat;
                if (wi1 >= 0 && wi1 < 512) mem1[wi1] = m1_wdata;
                w1_log.push_back(m1_wdata);
                if (exp_wide_q.size() == 0) w1_mism++;
                else begin
                    e1 = exp_wide_q.pop_front();
                    if (m1_wdata != e1) w1_mism++;
                end
                if (m1_wlast != (sb_wbeat == 255)) wlast1_err++;
                sb_wbeat++;
                if (m1_wlast) sb_bpend = 1;
            end
            if (m1_bvalid && m1_bready) sb_bpend = 0;
            if (m1_arvalid && m1_arready) begin
                sb_rd_addr = m1_araddr; sb_rbeat = 0; sb_ractive = 1;
            end
            if (m1_rvalid && m1_rready) begin
                sb_rbeat++;
                if (m1_rlast) sb_ractive = 0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic start_a(input logic mode, input logic [31:0] seed);
        logic [31:0] w;
        @(negedge clk);
        m0_init = 1'b0;
        aw_log.delete(); w_log.delete(); exp_q.delete();
        w_cnt = 0; w_mism = 0; wlast_err = 0; proto_err = 0; awfmt_err = 0; ar_cnt = 0; sa_bcnt = 0;
        w = (mode && seed == 32'd0) ? 32'd1 : seed;
        for (int n = 0; n < 64; n++) begin
            exp_q.push_back(w);
            w = mode ? lfsr_next(w) : w + 32'd1;
        end
        @(negedge clk);
        m0_mode = mode; m0_seed = seed; m0_init = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_done_a(input string tag);
        for (int i = 0; i < 4000 && !m0_done; i++) @(negedge clk);
        check(tag, m0_done, 1'b1);
    endtask

    task automatic start_b(input logic mode, input logic [31:0] seed);
        logic [31:0] w;
        logic [127:0] x;
        @(negedge clk);
        m1_init = 1'b0;
        aw1_log.delete(); w1_log.delete(); exp_wide_q.delete(); w1_mism = 0; wlast1_err = 0;
        w = (mode && seed == 32'd0) ? 32'd1 : seed;
        for (int n = 0; n < 512; n++) begin
            for (int l = 0; l < 4; l++) x[l*32 +: 32] = w ^ 32'(l);
            exp_wide_q.push_back(x);
            w = mode ? lfsr_next(w) : w + 32'd1;
        end
        @(negedge clk);
        m1_mode = mode; m1_seed = seed; m1_init = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        rst = 1'b1;
        m0_init = 1'b0; m0_mode = 1'b0; m0_seed = '0;
        m1_init = 1'b0; m1_mode = 1'b0; m1_seed = '0;
        sa_bp = 0; sa_corrupt = -1; sa_bad_b = -1; sa_bcnt = 0;
        repeat (3) @(negedge clk);
        check("rst_done", m0_done, 1'b0);
        check("rst_error", m0_err, 1'b0);
        check("rst_errcnt", m0_cnt, 16'd0);
        check("rst_valids", {m0_awvalid, m0_wvalid, m0_wlast, m0_bready, m0_arvalid, m0_rready}, 6'd0);
        check("rst_state", m0_dbg, 3'd0);
        rst = 1'b0;
        @(negedge clk);

        // 1: defaults, incrementing from 0, ideal slave
        start_a(1'b0, 32'd0);
        check("t1_awvalid_next_cycle", m0_awvalid, 1'b1);
        check("t1_first_awaddr", m0_awaddr, BASE);
        wait_done_a("t1_done");
        check("t1_wbeats", w_cnt, 64);
        check("t1_wdata_mism", w_mism, 0);
        check("t1_wbeat0", w_log[0], 32'd0);
        check("t1_wbeat63", w_log[63], 32'd63);
        check("t1_aw_count", aw_log.size(), 4);
        check("t1_awaddr1", aw_log[1], 32'h4000_0040);
        check("t1_awaddr3", aw_log[3], 32'h4000_00C0);
        check("t1_aw_format", awfmt_err, 0);
        check("t1_wlast", wlast_err, 0);
        check("t1_ar_count", ar_cnt, 4);
        check("t1_error", m0_err, 1'b0);
        check("t1_errcnt", m0_cnt, 16'd0);
        check("t1_awcache", m0_awcache, 4'b0011);

        // 2: corrupt global read beat 37
        sa_corrupt = 37;
        start_a(1'b0, 32'd0);
        wait_done_a("t2_done");
        check("t2_error", m0_err, 1'b1);
        check("t2_errcnt", m0_cnt, 16'd1);
        sa_corrupt = -1;

        // 3: random back-pressure, plus an INIT edge mid-pass that must be ignored
        sa_bp = 1;
        start_a(1'b0, 32'h0000_1234);
        repeat (30) @(negedge clk);
        m0_init = 1'b0;
        @(negedge clk);
        m0_init = 1'b1;
        wait_done_a("t3_done");
        check("t3_protocol", proto_err, 0);
        check("t3_wdata_mism", w_mism, 0);
        check("t3_wbeat5", w_log[5], 32'h0000_1239);
        check("t3_aw_count", aw_log.size(), 4);
        check("t3_wlast", wlast_err, 0);
        check("t3_error", m0_err, 1'b0);
        sa_bp = 0;

        // 4: 128-bit / 256-beat instance, LFSR with seed 0 forced to 1
        start_b(1'b1, 32'd0);
        for (int i = 0; i < 4000 && !m1_done; i++) @(negedge clk);
        check("t4_done", m1_done, 1'b1);
        check("t4_wbeat0", w1_log[0], 128'h00000002_00000003_00000000_00000001);
        check("t4_wbeat1", w1_log[1], 128'h80200000_80200001_80200002_80200003);
        check("t4_wdata_mism", w1_mism, 0);
        check("t4_aw_count", aw1_log.size(), 2);
        check("t4_awaddr1", aw1_log[1], 32'h4000_1000);
        check("t4_wlast", wlast1_err, 0);
        check("t4_len_size", {m1_awlen, m1_awsize}, {8'hFF, 3'd4});
        check("t4_wstrb", m1_wstrb, 16'hFFFF);
        check("t4_error", m1_err, 1'b0);
        check("t4_errcnt", m1_cnt, 16'd0);

        // 5: SLVERR on the third write response, then a clean restart in LFSR mode
        sa_bad_b = 2;
        start_a(1'b0, 32'h55);
        wait_done_a("t5_done_bad");
        check("t5_errcnt_bad", m0_cnt, 16'd1);
        check("t5_error_bad", m0_err, 1'b1);
        sa_bad_b = -1;
        start_a(1'b1, 32'h0000_ACE1);
        check("t5_errcnt_cleared", m0_cnt, 16'd0);
        check("t5_error_cleared", m0_err, 1'b0);
        check("t5_done_cleared", m0_done, 1'b0);
        wait_done_a("t5_done_clean");
        check("t5_wdata_mism", w_mism, 0);
        check("t5_errcnt_clean", m0_cnt, 16'd0);
        check("t5_error_clean", m0_err, 1'b0);

        // 6: reset during RD_DATA after an error has been counted
        sa_corrupt = 0;
        start_a(1'b0, 32'h100);
        for (int i = 0; i < 2000 && !(m0_rready && m0_err); i++) @(negedge clk);
        check("t6_reached_rd_err", {m0_rready, m0_err}, 2'b11);
        rst = 1'b1;
        @(negedge clk);
        check("t6_rst_rready", m0_rready, 1'b0);
        check("t6_rst_valids", {m0_awvalid, m0_wvalid, m0_arvalid, m0_bready}, 4'd0);
        check("t6_rst_err", {m0_err, m0_done}, 2'b00);
        check("t6_rst_errcnt", m0_cnt, 16'd0);
        check("t6_rst_state", m0_dbg, 3'd0);
        @(negedge clk);
        rst = 1'b0;
        sa_corrupt = -1;
        m0_init = 1'b0;
        start_a(1'b0, 32'd7);
        wait_done_a("t6_done");
        check("t6_wdata_mism", w_mism, 0);
        check("t6_aw_count", aw_log.size(), 4);
        check("t6_error", m0_err, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
